// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, NOP encoding, fetch state encoding and the
// legal-opcode check that fetch and decode share.
package riscv_pkg;

   localparam logic [4:0] OPC_RTYPE  = 5'b01100;
   localparam logic [4:0] OPC_ITYPE  = 5'b00100;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_e;

   function automatic logic is_illegal(input logic [31:0] inst);
      return inst[1:0] != 2'b11 ||
             !(inst[6:2] inside {OPC_RTYPE, OPC_ITYPE, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                                 OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR});
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO with flush; push and pop may coincide.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop && count_q != '0;
   assign do_push = push && (count_q != FULL || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end

   always_ff @(posedge clk)
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/ready fetch, instruction buffer and redirect handling.
// Define FETCH_ILLEGAL_CHECK_EN to add the inst_illegal output.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        inst_valid,
`ifdef FETCH_ILLEGAL_CHECK_EN
   output logic        inst_illegal,
`endif
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
`ifdef FETCH_ILLEGAL_CHECK_EN
   localparam int EW = 65;
`else
   localparam int EW = 64;
`endif

   fetch_state_e   state_q, state_d;
   logic [31:0]    pc_q, pc_d, dis_addr_q, dis_addr_d;
   logic           pend_q, pend_d;
   logic           has_room, accept, push, pop, empty;
   logic [CW-1:0]  count;
   logic [EW-1:0]  wdata, rdata;

   assign empty    = count == '0;
   assign has_room = count < CW'(BUF_DEPTH);

   // A request already on the bus stays up through a redirect; only new ones are held back.
   always_comb begin
      imem_req   = !rst && (state_q == DISCARD || pend_q || (has_room && !redirect_valid));
      imem_addr  = state_q == DISCARD ? dis_addr_q : pc_q;
      accept     = imem_req && imem_ready;
      push       = accept && state_q == FETCH && !redirect_valid;
      pop        = !empty && !stall;
      pc_d       = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
      state_d    = state_q == DISCARD ? (imem_ready ? FETCH : DISCARD)
                 : (redirect_valid && imem_req && !imem_ready ? DISCARD : FETCH);
      dis_addr_d = state_q == FETCH && state_d == DISCARD ? pc_q : dis_addr_q;
      pend_d     = imem_req && !imem_ready;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         dis_addr_q <= RESET_PC;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dis_addr_q <= dis_addr_d;
         pend_q     <= pend_d;
      end

`ifdef FETCH_ILLEGAL_CHECK_EN
   assign wdata        = {is_illegal(imem_rdata), pc_q, imem_rdata};
   assign inst_illegal = !empty && rdata[64];
`else
   assign wdata = {pc_q, imem_rdata};
`endif

   fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(EW)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .count (count)
   );

   assign inst_valid = !empty;
   assign inst_out   = empty ? NOP_INSTR : rdata[31:0];
   assign inst_pc    = empty ? 32'h0 : rdata[63:32];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a scoreboard of expected {pc, inst} deliveries.
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, imem_ready = 1'b1, redirect_valid = 1'b0;
   logic        stall = 1'b0, ill_mode = 1'b0;
   logic [31:0] redirect_pc = 32'h0, imem_rdata;
   logic        imem_req, inst_valid;
   logic [31:0] imem_addr, inst_out, inst_pc;
`ifdef FETCH_ILLEGAL_CHECK_EN
   logic        inst_illegal;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0, checks = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .inst_valid     (inst_valid),
`ifdef FETCH_ILLEGAL_CHECK_EN
      .inst_illegal   (inst_illegal),
`endif
      .inst_out       (inst_out),
      .inst_pc        (inst_pc)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC000_0000 | a;
   endfunction

   always_comb imem_rdata = ill_mode ? (imem_addr == 32'h0 ? 32'h0000_007F : 32'h0000_0033)
                                     : word(imem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
      exp_q.push_back({pc, inst});
   endtask

   // Every instruction decode consumes must be the next one the scoreboard expects.
   always @(negedge clk)
      if (!rst && inst_valid && !stall) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got pc %h inst %h, none expected", inst_pc, inst_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("deliver_pc_inst", {inst_pc, inst_out}, mon_e);
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) step();
      @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst_out, 32'h13);
      chk("rst_pc", inst_pc, 0);
      chk("rst_addr", imem_addr, 0);

      // sequential fetch, ready tied high
      for (int i = 0; i < 4; i++) expect_inst(32'(4 * i), word(32'(4 * i)));
      step(); rst = 1'b0;
      @(negedge clk);
      chk("t1_req0", imem_req, 1);
      chk("t1_addr0", imem_addr, 0);
      chk("t1_valid0", inst_valid, 0);
      step(); @(negedge clk);
      chk("t1_addr4", imem_addr, 4);
      chk("t1_valid1", inst_valid, 1);
      step(); @(negedge clk);
      chk("t1_addr8", imem_addr, 8);
      step(); step();
      step(); rst = 1'b1; stall = 1'b1;

      // stall fills the buffer, then ready stalls, then redirect during pending request
      expect_inst(32'h0, word(32'h0));
      expect_inst(32'h4, word(32'h4));
      expect_inst(32'h8, word(32'h8));
      expect_inst(32'hC, word(32'hC));
      expect_inst(32'h200, word(32'h200));
      expect_inst(32'h204, word(32'h204));
      step(); rst = 1'b0;
      step();
      step(); @(negedge clk);
      chk("t2_req_full", imem_req, 0);
      chk("t2_hold_pc", inst_pc, 0);
      chk("t2_hold_inst", inst_out, word(32'h0));
      chk("t2_hold_valid", inst_valid, 1);
      step(); step(); step();
      step(); stall = 1'b0;
      @(negedge clk);
      chk("t2_req_still_full", imem_req, 0);
      step(); @(negedge clk);
      chk("t2_resume_req", imem_req, 1);
      chk("t2_resume_addr", imem_addr, 8);
      step();
      step(); imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_req_hold", imem_req, 1);
         chk("t3_addr_hold", imem_addr, 32'h10);
         if (k > 0) chk("t3_drained", inst_valid, 0);
         step();
      end
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      chk("t4_req_kept", imem_req, 1);
      chk("t4_addr_kept", imem_addr, 32'h10);
      step(); redirect_valid = 1'b0; imem_ready = 1'b1;
      @(negedge clk);
      chk("t4_discard_addr", imem_addr, 32'h10);
      chk("t4_discard_valid", inst_valid, 0);
      step(); @(negedge clk);
      chk("t4_new_req", imem_req, 1);
      chk("t4_new_addr", imem_addr, 32'h200);
      step();
      step(); imem_ready = 1'b0;
      step(); redirect_valid = 1'b1; redirect_pc = 32'h24;
      step(); redirect_valid = 1'b0; imem_ready = 1'b1;
      step(); imem_ready = 1'b0;
      @(negedge clk);
      chk("t5_wait_req", imem_req, 1);
      chk("t5_wait_addr", imem_addr, 32'h24);

      // asynchronous reset in the middle of a pending request
      step(); rst = 1'b1;
      #1;
      chk("t5_rst_req", imem_req, 0);
      chk("t5_rst_valid", inst_valid, 0);
      chk("t5_rst_inst", inst_out, 32'h13);
      chk("t5_rst_addr", imem_addr, 0);
      imem_ready = 1'b1;
      expect_inst(32'h0, word(32'h0));
      step(); rst = 1'b0;
      @(negedge clk);
      chk("t5_restart_req", imem_req, 1);
      chk("t5_restart_addr", imem_addr, 0);
      step();
      step(); stall = 1'b1;

`ifdef FETCH_ILLEGAL_CHECK_EN
      step(); rst = 1'b1; ill_mode = 1'b1;
      expect_inst(32'h0, 32'h0000_007F);
      expect_inst(32'h4, 32'h0000_0033);
      step(); rst = 1'b0;
      step(); @(negedge clk);
      chk("t6_illegal_7f", inst_illegal, 1);
      chk("t6_valid", inst_valid, 1);
      step(); stall = 1'b0;
      step(); @(negedge clk);
      chk("t6_legal_33", inst_illegal, 0);
      chk("t6_pc", inst_pc, 4);
      step(); stall = 1'b1;
`endif

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
